pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central stall/flush controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB). It detects load-use hazards and taken branches (B, B.cond/B.LT, CBZ), as well as data-memory wait states. From these it drives the PC write enable, the pipeline-register enables and the bubble/flush controls. A branch that resolves during a memory freeze is held and applied once the pipeline unfreezes. Saturating counters track stall and flush events for performance analysis.

## Interface
- `REG_W`, 5, register-index width
- `CNT_W`, 16, performance-counter width
- `ZERO_REG`, 31, index of XZR; never a hazard source

- `clk` in 1 rising-edge clock
- `reset` in 1 asynchronous, active-high reset
- `id_ex_mem_read` in 1 instruction in ID/EX is a load (LDUR)
- `id_ex_rd` in REG_W destination of the ID/EX instruction
- `if_id_rn`, `if_id_rm` in REG_W source registers of the instruction in IF/ID
- `if_id_uses_rn`, `if_id_uses_rm` in 1 the corresponding source is actually read
- `ex_br_taken` in 1 branch resolved taken in EX this cycle
- `mem_busy` in 1 data memory not ready; the MEM access must repeat
- `pc_write` out 1 PC register load enable
- `if_id_write` out 1 IF/ID register enable
- `if_id_flush` out 1 load a NOP into IF/ID
- `id_ex_bubble` out 1 zero the control fields entering ID/EX
- `pipe_en` out 1 enable for ID/EX, EX/MEM and MEM/WB
- `br_redirect` out 1 select the branch target as next PC
- `stall_cnt` out CNT_W load-use stall cycles, saturating
- `flush_cnt` out CNT_W branch flush events, saturating

## Operation
- Load-use hazard `lu` = `id_ex_mem_read` & `id_ex_rd`≠`ZERO_REG` & ((`if_id_uses_rn` & `id_ex_rd`==`if_id_rn`) | (`if_id_uses_rm` & `id_ex_rd`==`if_id_rm`)).
- State machine states:
  - **RUN**: normal operation.
  - **FREEZE**: `mem_busy` is being honoured.
  - **REDIRECT**: a branch held during a freeze is being applied.
- Branch hold: the registered flag `br_pend` captures `ex_br_taken` seen while `mem_busy`=1. Its target is held in the frozen EX/MEM register.
- Priority each cycle is `mem_busy` > branch (`ex_br_taken` or REDIRECT) > `lu`.
- **Freeze** (`mem_busy`=1, any state):
  - `pipe_en`=0, `pc_write`=0, `if_id_write`=0; no bubble, no flush.
  - Next state is FREEZE.
  - `br_pend` is set if `ex_br_taken`.
- **Branch** (RUN with `ex_br_taken`=1, or REDIRECT):
  - `pc_write`=1, `br_redirect`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_bubble`=1, `pipe_en`=1.
  - `flush_cnt`++ and `br_pend` clears.
  - Next state is RUN.
- **Load-use** (RUN, no branch, `lu`=1):
  - `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1, `pipe_en`=1.
  - `stall_cnt`++.
  - The following cycle re-evaluates; ID/EX then holds a bubble, so the stall lasts exactly one cycle.
- **Normal** (none of the above): all enables are 1; bubble, flush and redirect are 0.
- Leaving FREEZE when `mem_busy` drops:
  - Next state is REDIRECT if `br_pend`, else RUN.
  - In that same first cycle, outputs follow the RUN rules with the live inputs.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from current state, `br_pend` and inputs, valid in the same cycle. There are no registered output delays.
- The state, `br_pend` and both counters update on the rising edge of `clk`.
- Branch penalty is 2 cycles: the IF/ID and ID/EX wrong-path instructions are killed.
- Load-use penalty is 1 cycle.
- Reset, asserted asynchronously:
  - State becomes RUN; `br_pend`=0; counters become 0.
  - While `reset`=1: `pc_write`=0, `if_id_write`=0, `pipe_en`=0, `if_id_flush`=1, `id_ex_bubble`=1, `br_redirect`=0.
- Reset during FREEZE or with a pending branch discards the branch.
- `ex_br_taken` and `lu` in the same cycle: the branch wins and `stall_cnt` is unchanged.

## Structure
- A shared package `cpu_pkg` holds:
  - `REG_W` and `ZERO_REG`;
  - enum `seq_state_t` {RUN, FREEZE, REDIRECT}.
- One sub-module: `load_use_detect`, purely combinational, computing `lu`. The FSM, hold flag and counters stay in the top level.

## Test plan
- Load X1 in ID/EX, with a following ADD reading X1 as Rn in IF/ID → one cycle with `pc_write`=0 and `id_ex_bubble`=1; next cycle normal; `stall_cnt`=1.
- Load into X31 with a consumer reading X31 → no stall; `stall_cnt` stays 0.
- `ex_br_taken`=1 and `lu`=1 together → `if_id_flush`=1, `id_ex_bubble`=1, `br_redirect`=1; `flush_cnt`=1; `stall_cnt`=0.
- `mem_busy` high for 3 cycles with `ex_br_taken` pulsed in cycle 1 → 3 freeze cycles (`pipe_en`=0), then one REDIRECT cycle with `br_redirect`=1, then RUN.
- `stall_cnt` preloaded to near saturation by forcing 2^CNT_W+2 stalls → `stall_cnt` holds at all-ones.
- Reset asserted mid-FREEZE with `br_pend`=1 → immediate reset outputs; after release, RUN with no redirect and counters at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the pipeline sequencer
// state encoding.
package cpu_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    RUN,
    FREEZE,
    REDIRECT
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard inputs from the datapath and stall/flush controls back to it.
// The datapath is the master; the sequencer is the slave.
interface pipeline_sequencer_if #(
  parameter int unsigned REG_W = cpu_pkg::REG_W,
  parameter int unsigned CNT_W = cpu_pkg::CNT_W
);

  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] if_id_rn;
  logic [REG_W-1:0] if_id_rm;
  logic             if_id_uses_rn;
  logic             if_id_uses_rm;
  logic             ex_br_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_en;
  logic             br_redirect;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rn, if_id_rm,
           if_id_uses_rn, if_id_uses_rm, ex_br_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_en, br_redirect, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rn, if_id_rm,
           if_id_uses_rn, if_id_uses_rm, ex_br_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_en, br_redirect, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard detector: a load in ID/EX whose destination
// is read by the instruction in IF/ID. XZR never creates a dependency.
module load_use_detect #(
  parameter int unsigned REG_W    = cpu_pkg::REG_W,
  parameter int unsigned ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rn,
  input  logic [REG_W-1:0] if_id_rm,
  input  logic             if_id_uses_rn,
  input  logic             if_id_uses_rm,
  output logic             lu
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic hit_rn;
  logic hit_rm;

  always_comb begin
    hit_rn = if_id_uses_rn && (id_ex_rd == if_id_rn);
    hit_rm = if_id_uses_rm && (id_ex_rd == if_id_rm);
    lu     = id_ex_mem_read && (id_ex_rd != ZR) && (hit_rn || hit_rm);
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory freezes and saturating event counters.
module pipeline_sequencer #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ZERO_REG = 31
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_sequencer_if.slave bus
);

  import cpu_pkg::*;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             br_pend;
  logic             br_pend_nxt;
  logic             lu;
  logic             do_branch;
  logic             do_stall;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  load_use_detect #(
    .REG_W   (REG_W),
    .ZERO_REG(ZERO_REG)
  ) u_lu (
    .id_ex_mem_read(bus.id_ex_mem_read),
    .id_ex_rd      (bus.id_ex_rd),
    .if_id_rn      (bus.if_id_rn),
    .if_id_rm      (bus.if_id_rm),
    .if_id_uses_rn (bus.if_id_uses_rn),
    .if_id_uses_rm (bus.if_id_uses_rm),
    .lu            (lu)
  );

  // Freeze outranks everything; the first cycle out of FREEZE behaves as RUN.
  always_comb begin
    do_branch = !bus.mem_busy && (bus.ex_br_taken || (state == REDIRECT));
    do_stall  = !bus.mem_busy && !do_branch && lu;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      br_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      br_pend <= br_pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = RUN;
    br_pend_nxt = br_pend;
    if (bus.mem_busy) begin
      state_nxt   = FREEZE;
      br_pend_nxt = br_pend || bus.ex_br_taken;
    end else begin
      if ((state == FREEZE) && br_pend) state_nxt = REDIRECT;
      if (do_branch) br_pend_nxt = 1'b0;
    end
  end

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.pipe_en      = 1'b1;
    bus.br_redirect  = 1'b0;
    if (reset) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      bus.pipe_en      = 1'b0;
    end else if (bus.mem_busy) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.pipe_en     = 1'b0;
    end else if (do_branch) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      bus.br_redirect  = 1'b1;
    end else if (do_stall) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (do_branch && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a flag-based reference model.
module tb_pipeline_sequencer;

  localparam int unsigned CNT_W = 10;
  localparam int SAT = (1 << CNT_W) - 1;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, br_redirect}
  localparam logic [5:0] O_RESET  = 6'b001100;
  localparam logic [5:0] O_FREEZE = 6'b000000;
  localparam logic [5:0] O_BRANCH = 6'b111111;
  localparam logic [5:0] O_STALL  = 6'b000110;
  localparam logic [5:0] O_NORMAL = 6'b110010;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  // reference model: frozen last cycle, branch held, redirect owed this cycle
  bit m_frozen, m_pend, m_redir;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.REG_W(5), .CNT_W(CNT_W)) bus ();

  pipeline_sequencer #(
    .REG_W   (5),
    .CNT_W   (CNT_W),
    .ZERO_REG(31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [5:0] obs;
  assign obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_bubble, bus.pipe_en, bus.br_redirect};

  task automatic apply(input bit mr, input int rd, input int rn, input int rm,
                       input bit urn, input bit urm, input bit br, input bit busy);
    @(negedge clk);
    bus.id_ex_mem_read = mr;
    bus.id_ex_rd       = 5'(rd);
    bus.if_id_rn       = 5'(rn);
    bus.if_id_rm       = 5'(rm);
    bus.if_id_uses_rn  = urn;
    bus.if_id_uses_rm  = urm;
    bus.ex_br_taken    = br;
    bus.mem_busy       = busy;
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    m_frozen = 0; m_pend = 0; m_redir = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    vecs++;
    if ({obs, bus.stall_cnt, bus.flush_cnt} !== {O_RESET, CNT_W'(0), CNT_W'(0)}) begin
      errs++;
      $display("FAIL reset_state: got %b s=%0d f=%0d, want %b s=0 f=0",
               obs, bus.stall_cnt, bus.flush_cnt, O_RESET);
    end
    reset_dut();
  endtask

  task automatic test_load_use();
    reset_dut();
    apply(1, 1, 1, 7, 1, 1, 0, 0);
    vecs++;
    if (obs !== O_STALL) begin
      errs++; $display("FAIL lu_stall: got %b want %b", obs, O_STALL);
    end
    apply(0, 0, 1, 7, 1, 1, 0, 0);
    vecs++;
    if ({obs, bus.stall_cnt} !== {O_NORMAL, CNT_W'(1)}) begin
      errs++; $display("FAIL lu_after: got %b s=%0d want %b s=1", obs, bus.stall_cnt, O_NORMAL);
    end
    apply(1, 4, 2, 4, 0, 1, 0, 0);
    vecs++;
    if (obs !== O_STALL) begin
      errs++; $display("FAIL lu_rm: got %b want %b", obs, O_STALL);
    end
    apply(1, 4, 4, 4, 0, 0, 0, 0);
    vecs++;
    if ({obs, bus.stall_cnt} !== {O_NORMAL, CNT_W'(2)}) begin
      errs++; $display("FAIL lu_unused_src: got %b s=%0d want %b s=2", obs, bus.stall_cnt, O_NORMAL);
    end
  endtask

  task automatic test_zero_reg();
    reset_dut();
    apply(1, 31, 31, 31, 1, 1, 0, 0);
    vecs++;
    if (obs !== O_NORMAL) begin
      errs++; $display("FAIL xzr_no_stall: got %b want %b", obs, O_NORMAL);
    end
    idle();
    vecs++;
    if (bus.stall_cnt !== CNT_W'(0)) begin
      errs++; $display("FAIL xzr_cnt: got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_branch_vs_lu();
    reset_dut();
    apply(1, 3, 3, 0, 1, 0, 1, 0);
    vecs++;
    if (obs !== O_BRANCH) begin
      errs++; $display("FAIL br_wins: got %b want %b", obs, O_BRANCH);
    end
    idle();
    vecs++;
    if ({obs, bus.stall_cnt, bus.flush_cnt} !== {O_NORMAL, CNT_W'(0), CNT_W'(1)}) begin
      errs++; $display("FAIL br_wins_cnt: got %b s=%0d f=%0d want %b s=0 f=1",
                       obs, bus.stall_cnt, bus.flush_cnt, O_NORMAL);
    end
  endtask

  task automatic test_freeze_redirect();
    logic [5:0] want [6];
    want = '{O_FREEZE, O_FREEZE, O_FREEZE, O_NORMAL, O_BRANCH, O_NORMAL};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 0, 0, 0, 0, i == 0, i < 3);
      vecs++;
      if (obs !== want[i]) begin
        errs++; $display("FAIL freeze_seq[%0d]: got %b want %b", i, obs, want[i]);
      end
    end
    vecs++;
    if (bus.flush_cnt !== CNT_W'(1)) begin
      errs++; $display("FAIL freeze_flush_cnt: got %0d want 1", bus.flush_cnt);
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < (1 << CNT_W) + 2; i++) apply(1, 2, 2, 0, 1, 0, 0, 0);
    idle();
    vecs++;
    if (bus.stall_cnt !== CNT_W'(SAT)) begin
      errs++; $display("FAIL stall_sat: got %0d want %0d", bus.stall_cnt, SAT);
    end
  endtask

  task automatic test_reset_mid_freeze();
    reset_dut();
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    vecs++;
    if ({obs, bus.flush_cnt} !== {O_RESET, CNT_W'(0)}) begin
      errs++; $display("FAIL async_reset: got %b f=%0d want %b f=0", obs, bus.flush_cnt, O_RESET);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      vecs++;
      if ({obs, bus.flush_cnt, bus.stall_cnt} !== {O_NORMAL, CNT_W'(0), CNT_W'(0)}) begin
        errs++; $display("FAIL post_reset[%0d]: got %b f=%0d s=%0d want %b f=0 s=0",
                         i, obs, bus.flush_cnt, bus.stall_cnt, O_NORMAL);
      end
    end
  endtask

  task automatic test_random();
    int regs [5] = '{0, 1, 2, 3, 31};
    bit mr, urn, urm, br, busy, lu, br_act, new_redir;
    int rd, rn, rm;
    logic [5:0] exp_o;
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      mr   = $urandom_range(0, 1);
      urn  = $urandom_range(0, 1);
      urm  = $urandom_range(0, 1);
      br   = ($urandom_range(0, 4) == 0);
      busy = ($urandom_range(0, 3) == 0);
      rd   = regs[$urandom_range(0, 4)];
      rn   = regs[$urandom_range(0, 4)];
      rm   = regs[$urandom_range(0, 4)];
      apply(mr, rd, rn, rm, urn, urm, br, busy);
      lu = mr && rd != 31 && ((urn && rd == rn) || (urm && rd == rm));
      if (busy) exp_o = O_FREEZE;
      else if (br || m_redir) exp_o = O_BRANCH;
      else if (lu) exp_o = O_STALL;
      else exp_o = O_NORMAL;
      vecs++;
      if ({obs, bus.stall_cnt, bus.flush_cnt} !== {exp_o, CNT_W'(m_stall), CNT_W'(m_flush)}) begin
        errs++;
        $display("FAIL random[%0d]: got %b s=%0d f=%0d want %b s=%0d f=%0d",
                 n, obs, bus.stall_cnt, bus.flush_cnt, exp_o, m_stall, m_flush);
      end
      if (busy) begin
        m_pend   = m_pend || br;
        m_frozen = 1;
        m_redir  = 0;
      end else begin
        br_act    = br || m_redir;
        new_redir = m_frozen && m_pend;
        if (br_act) begin
          if (m_flush < SAT) m_flush++;
          m_pend = 0;
        end else if (lu && m_stall < SAT) begin
          m_stall++;
        end
        m_redir  = new_redir;
        m_frozen = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_vs_lu();
    test_freeze_redirect();
    test_saturation();
    test_reset_mid_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
